// File: rtl/draw_pkg.sv
// Shared pixel-colour types and constants for the VGA drawing pipeline.
package draw_pkg;

  typedef logic [7:0] rgb8_t;

  localparam rgb8_t RGB_BLACK = 8'h00;

  // Colour byte layout is {B[1:0], R[2:0], G[2:0]}
  localparam int RGB_B_HI = 7;
  localparam int RGB_B_LO = 6;
  localparam int RGB_R_HI = 5;
  localparam int RGB_R_LO = 3;
  localparam int RGB_G_HI = 2;
  localparam int RGB_G_LO = 0;

  localparam int MAX_GHOSTS  = 8;
  localparam int GHOST_SEL_W = 3;

endpackage

// File: rtl/frame_once_pulse.sv
// Emits a registered one-cycle pulse on the first hit of each frame.
// A hit on the startOfFrame pixel counts toward the new frame.
module frame_once_pulse (
  input  logic clk,
  input  logic resetN,
  input  logic startOfFrame,
  input  logic hit,
  output logic pulse
);

  logic flag_reg;
  logic pulse_reg;
  logic flag_eff;
  logic fire;

  assign flag_eff = startOfFrame ? 1'b0 : flag_reg;
  assign fire     = hit && !flag_eff;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      flag_reg  <= 1'b0;
      pulse_reg <= 1'b0;
    end else begin
      pulse_reg <= fire;
      flag_reg  <= fire ? 1'b1 : flag_eff;
    end
  end

  assign pulse = pulse_reg;

endmodule

// File: rtl/draw_priority_mux.sv
// Pixel colour priority mux (Pacman > ghosts > background) with per-frame
// collision pulses, built only when PRIORITY_MUX_COLLISION_EN is defined.
module draw_priority_mux
  import draw_pkg::*;
#(
  parameter int NUM_GHOSTS  = 4,
  parameter int GHOST_IDX_W = 3
) (
  input  logic                    clk,
  input  logic                    resetN,
  input  logic                    startOfFrame,
  input  logic                    pacmanDrawReq,
  input  logic [7:0]              pacmanRGB,
  input  logic [NUM_GHOSTS-1:0]   ghostDrawReq,
  input  logic [NUM_GHOSTS*8-1:0] ghostRGB,
  input  logic                    boardersDrawReq,
  input  logic [7:0]              BG_RGB,
  output logic [7:0]              RGBOut,
  output logic                    pacBorderHit,
  output logic                    pacGhostHit,
  output logic [GHOST_IDX_W-1:0]  ghostHitIdx
);

  // Lowest set request wins; an empty vector yields index 0.
  function automatic logic [GHOST_SEL_W-1:0] first_ghost(input logic [MAX_GHOSTS-1:0] req);
    logic [GHOST_SEL_W-1:0] idx;
    idx = '0;
    for (int i = MAX_GHOSTS - 1; i >= 0; i--) begin
      if (req[i]) idx = GHOST_SEL_W'(i);
    end
    return idx;
  endfunction

  // Pad ghost inputs to MAX_GHOSTS so absent slots read as inactive black.
  logic [MAX_GHOSTS-1:0] ghost_req_ext;
  rgb8_t                 ghost_rgb [MAX_GHOSTS];

  genvar gi;
  generate
    for (gi = 0; gi < MAX_GHOSTS; gi++) begin : g_ghost
      if (gi < NUM_GHOSTS) begin : g_real
        assign ghost_req_ext[gi] = ghostDrawReq[gi];
        assign ghost_rgb[gi]     = ghostRGB[gi*8 +: 8];
      end else begin : g_absent
        assign ghost_req_ext[gi] = 1'b0;
        assign ghost_rgb[gi]     = RGB_BLACK;
      end
    end
  endgenerate

  logic [GHOST_SEL_W-1:0] ghost_sel;
  logic                   any_ghost;
  rgb8_t                  rgb_next;
  rgb8_t                  rgb_reg;

  assign ghost_sel = first_ghost(ghost_req_ext);
  assign any_ghost = |ghost_req_ext;

  always_comb begin
    rgb_next = BG_RGB;
    if (pacmanDrawReq)  rgb_next = pacmanRGB;
    else if (any_ghost) rgb_next = ghost_rgb[ghost_sel];
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) rgb_reg <= RGB_BLACK;
    else         rgb_reg <= rgb_next;
  end

  assign RGBOut = rgb_reg;

`ifdef PRIORITY_MUX_COLLISION_EN
  logic [GHOST_IDX_W-1:0] hit_idx;
  logic [GHOST_IDX_W-1:0] idx_pend_reg;
  logic [GHOST_IDX_W-1:0] idx_hold_reg;

  assign hit_idx = GHOST_IDX_W'(ghost_sel);

  frame_once_pulse u_border_once (
    .clk          (clk),
    .resetN       (resetN),
    .startOfFrame (startOfFrame),
    .hit          (pacmanDrawReq && boardersDrawReq),
    .pulse        (pacBorderHit)
  );

  frame_once_pulse u_ghost_once (
    .clk          (clk),
    .resetN       (resetN),
    .startOfFrame (startOfFrame),
    .hit          (pacmanDrawReq && any_ghost),
    .pulse        (pacGhostHit)
  );

  // Pending index tracks the pulse's pixel; it is exposed only while the pulse is up.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      idx_pend_reg <= '0;
      idx_hold_reg <= '0;
    end else begin
      idx_pend_reg <= hit_idx;
      idx_hold_reg <= ghostHitIdx;
    end
  end

  assign ghostHitIdx = pacGhostHit ? idx_pend_reg : idx_hold_reg;
`else
  logic unused_collision_inputs;
  assign unused_collision_inputs = &{1'b0, startOfFrame, boardersDrawReq};

  assign pacBorderHit = 1'b0;
  assign pacGhostHit  = 1'b0;
  assign ghostHitIdx  = '0;
`endif

endmodule

// File: tb/tb_draw_priority_mux.sv
// Directed-vector bench for draw_priority_mux; collision expectations follow
// PRIORITY_MUX_COLLISION_EN the same way the design build does.
module tb_draw_priority_mux;

`ifdef PRIORITY_MUX_COLLISION_EN
  localparam bit COL = 1'b1;
`else
  localparam bit COL = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetN;
  logic        startOfFrame;
  logic        pacmanDrawReq;
  logic [7:0]  pacmanRGB;
  logic [3:0]  ghostDrawReq;
  logic [31:0] ghostRGB;
  logic        boardersDrawReq;
  logic [7:0]  BG_RGB;
  logic [7:0]  RGBOut;
  logic        pacBorderHit;
  logic        pacGhostHit;
  logic [2:0]  ghostHitIdx;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  draw_priority_mux #(.NUM_GHOSTS(4), .GHOST_IDX_W(3)) dut (
    .clk             (clk),
    .resetN          (resetN),
    .startOfFrame    (startOfFrame),
    .pacmanDrawReq   (pacmanDrawReq),
    .pacmanRGB       (pacmanRGB),
    .ghostDrawReq    (ghostDrawReq),
    .ghostRGB        (ghostRGB),
    .boardersDrawReq (boardersDrawReq),
    .BG_RGB          (BG_RGB),
    .RGBOut          (RGBOut),
    .pacBorderHit    (pacBorderHit),
    .pacGhostHit     (pacGhostHit),
    .ghostHitIdx     (ghostHitIdx)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [7:0] rgb, input logic bh,
                         input logic gh, input logic [2:0] idx);
    chk({tag, ".rgb"}, 32'(RGBOut), 32'(rgb));
    chk({tag, ".border"}, 32'(pacBorderHit), 32'(bh & COL));
    chk({tag, ".ghost"}, 32'(pacGhostHit), 32'(gh & COL));
    chk({tag, ".idx"}, 32'(ghostHitIdx), COL ? 32'(idx) : 32'd0);
    $display("vec %-12s rgb=%02h border=%0b ghost=%0b idx=%0d", tag, RGBOut,
             pacBorderHit, pacGhostHit, ghostHitIdx);
  endtask

  initial begin
    resetN = 1'b0; startOfFrame = 1'b0; pacmanDrawReq = 1'b0; pacmanRGB = 8'hE0;
    ghostDrawReq = 4'b0000; ghostRGB = {8'h2A, 8'h18, 8'h07, 8'hC1};
    boardersDrawReq = 1'b0; BG_RGB = 8'h3C;
    step(); step();
    chk_all("reset", 8'h00, 1'b0, 1'b0, 3'd0);
    resetN = 1'b1;

    // Background only
    step();
    chk_all("bg", 8'h3C, 1'b0, 1'b0, 3'd0);

    // Pacman over ghosts 1,2: first overlap after reset reports without startOfFrame
    pacmanDrawReq = 1'b1; ghostDrawReq = 4'b0110;
    step();
    chk_all("prio_pac", 8'hE0, 1'b0, 1'b1, 3'd1);
    pacmanDrawReq = 1'b0;
    step();
    chk_all("prio_ghost", 8'h07, 1'b0, 1'b0, 3'd1);

    // Border hit for 5 cycles: single pulse on the first
    ghostDrawReq = 4'b0000; startOfFrame = 1'b1;
    step();
    startOfFrame = 1'b0; pacmanDrawReq = 1'b1; boardersDrawReq = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk_all($sformatf("border%0d", i), 8'hE0, i == 0, 1'b0, 3'd1);
    end
    pacmanDrawReq = 1'b0;
    step();
    chk_all("border_gap", 8'h3C, 1'b0, 1'b0, 3'd1);
    pacmanDrawReq = 1'b1;
    step();
    chk_all("border_again", 8'hE0, 1'b0, 1'b0, 3'd1);

    // Ghost hit index across two frames
    pacmanDrawReq = 1'b0; boardersDrawReq = 1'b0; startOfFrame = 1'b1;
    step();
    startOfFrame = 1'b0; pacmanDrawReq = 1'b1; ghostDrawReq = 4'b1100;
    step();
    chk_all("gidx2", 8'hE0, 1'b0, 1'b1, 3'd2);
    pacmanDrawReq = 1'b0;
    step();
    chk_all("gidx2_hold", 8'h18, 1'b0, 1'b0, 3'd2);
    ghostDrawReq = 4'b0000; startOfFrame = 1'b1;
    step();
    startOfFrame = 1'b0; pacmanDrawReq = 1'b1; ghostDrawReq = 4'b1000;
    step();
    chk_all("gidx3", 8'hE0, 1'b0, 1'b1, 3'd3);

    // Overlap coincident with startOfFrame: exactly one pulse, then none
    startOfFrame = 1'b1; boardersDrawReq = 1'b1; ghostDrawReq = 4'b0010;
    step();
    chk_all("sof_coinc", 8'hE0, 1'b1, 1'b1, 3'd1);
    startOfFrame = 1'b0;
    step();
    chk_all("sof_next", 8'hE0, 1'b0, 1'b0, 3'd1);

    // Reset mid-frame: immediate clear, then first overlap reports
    resetN = 1'b0; ghostDrawReq = 4'b0100;
    #1;
    chk_all("rst_async", 8'h00, 1'b0, 1'b0, 3'd0);
    step();
    chk_all("rst_hold", 8'h00, 1'b0, 1'b0, 3'd0);
    resetN = 1'b1;
    step();
    chk_all("rst_after", 8'hE0, 1'b1, 1'b1, 3'd2);
    pacmanDrawReq = 1'b0; boardersDrawReq = 1'b0; ghostDrawReq = 4'b0000; BG_RGB = 8'h5A;
    step();
    chk_all("bg_end", 8'h5A, 1'b0, 1'b0, 3'd2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
